// File: rtl/pw_pkg.sv
// Shared types and constants for the password incrementer.
package pw_pkg;

  localparam int MAX_LEN = 20;
  localparam int LEN_W   = 5;
  localparam int PW_W    = 8 * MAX_LEN;

  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] OVF_LEN   = LEN_W'(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pw_state_t;

endpackage

// File: rtl/pw_char_inc.sv
// Single-digit increment over the printable range; wraps CHAR_MAX to CHAR_MIN with carry.
module pw_char_inc
  import pw_pkg::*;
(
  input  logic [7:0] ch,
  output logic [7:0] ch_inc,
  output logic       carry
);

  always_comb begin
    ch_inc = ch + 8'd1;
    carry  = 1'b0;
    if (ch >= CHAR_MAX) begin
      ch_inc = CHAR_MIN;
      carry  = 1'b1;
    end
  end

endmodule

// File: rtl/pwadder_core.sv
// Odometer-style next-candidate generator: one digit position per cycle,
// with a rising-edge trigger and a completed flag.
module pwadder_core
  import pw_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic [PW_W-1:0]   in_password,
  input  logic [LEN_W-1:0]  in_length,
  input  logic              trigger,
  output logic [PW_W-1:0]   out_password,
  output logic [LEN_W-1:0]  out_length,
  output logic              completed
);

  pw_state_t        state_reg;
  logic             trig_prev_reg;
  logic [7:0]       pw_reg [MAX_LEN];
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] idx_reg;
  logic             completed_reg;

  logic [7:0]       in_bytes [MAX_LEN];
  logic [7:0]       cur_byte;
  logic [7:0]       next_byte;
  logic             next_carry;
  logic             start;
  logic [LEN_W-1:0] len_clamped;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_bytes
      assign in_bytes[gi]              = in_password[8*gi +: 8];
      assign out_password[8*gi +: 8]   = pw_reg[gi];
    end
  endgenerate

  assign out_length  = len_reg;
  assign completed   = completed_reg;
  assign start       = trigger && !trig_prev_reg && (state_reg != RUN);
  assign len_clamped = (in_length > MAX_LEN_V) ? MAX_LEN_V : in_length;

  // idx can reach MAX_LEN after a full wrap; never index past the array then.
  always_comb begin
    cur_byte = CHAR_MIN;
    if (idx_reg < MAX_LEN_V)
      cur_byte = pw_reg[idx_reg];
  end

  pw_char_inc u_char_inc (
    .ch     (cur_byte),
    .ch_inc (next_byte),
    .carry  (next_carry)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      trig_prev_reg <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++)
        pw_reg[i] <= CHAR_MIN;
      len_reg       <= '0;
      idx_reg       <= '0;
      completed_reg <= 1'b0;
    end else begin
      trig_prev_reg <= trigger;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            for (int i = 0; i < MAX_LEN; i++)
              pw_reg[i] <= in_bytes[i];
            len_reg       <= len_clamped;
            idx_reg       <= '0;
            completed_reg <= 1'b0;
            state_reg     <= RUN;
          end
        end
        RUN: begin
          if (idx_reg == MAX_LEN_V) begin
            for (int i = 0; i < MAX_LEN; i++)
              pw_reg[i] <= CHAR_MIN;
            len_reg       <= OVF_LEN;
            completed_reg <= 1'b1;
            state_reg     <= DONE;
          end else if (idx_reg == len_reg) begin
            // Carry ran past the current length: append a fresh digit.
            pw_reg[idx_reg] <= CHAR_MIN;
            len_reg         <= len_reg + LEN_W'(1);
            completed_reg   <= 1'b1;
            state_reg       <= DONE;
          end else begin
            pw_reg[idx_reg] <= next_byte;
            if (next_carry) begin
              idx_reg <= idx_reg + LEN_W'(1);
            end else begin
              completed_reg <= 1'b1;
              state_reg     <= DONE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwadder_core.sv
// Directed bench for pwadder_core with hand-computed expected candidates.
module tb_pwadder_core;

  logic         clk;
  logic         nrst;
  logic [159:0] in_password;
  logic [4:0]   in_length;
  logic         trigger;
  logic [159:0] out_password;
  logic [4:0]   out_length;
  logic         completed;

  int n_assert = 0;
  int n_fail   = 0;
  int cycles;
  logic done_all;

  localparam logic [159:0] ALL_SP = {20{8'h20}};

  pwadder_core dut (
    .clk          (clk),
    .nrst         (nrst),
    .in_password  (in_password),
    .in_length    (in_length),
    .trigger      (trigger),
    .out_password (out_password),
    .out_length   (out_length),
    .completed    (completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [159:0] pw, input logic [4:0] len);
    @(negedge clk);
    in_password = pw;
    in_length   = len;
    trigger     = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (completed !== 1'b1 && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic do_op(input string tag, input logic [159:0] pw, input logic [4:0] len,
                       input logic [159:0] exp_pw, input logic [4:0] exp_len);
    int c;
    start_op(pw, len);
    wait_done(c);
    $display("op %s: len %0d -> %0d, pw %h, %0d cycles", tag, len, out_length, out_password, c);
    check({tag, "_done"}, {159'd0, completed}, 160'd1);
    check({tag, "_pw"}, out_password, exp_pw);
    check({tag, "_len"}, {155'd0, out_length}, {155'd0, exp_len});
  endtask

  initial begin
    nrst        = 1'b0;
    in_password = '0;
    in_length   = '0;
    trigger     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pw", out_password, ALL_SP);
    check("rst_len", {155'd0, out_length}, 160'd0);
    check("rst_done", {159'd0, completed}, 160'd0);
    @(negedge clk);
    nrst = 1'b1;

    do_op("len0", ALL_SP, 5'd0, ALL_SP, 5'd1);
    do_op("len0_b0", {{19{8'h20}}, 8'h33}, 5'd0, ALL_SP, 5'd1);

    // Carry-free op: latency is one edge after the latching edge.
    start_op(ALL_SP, 5'd1);
    wait_done(cycles);
    check("lat1", 160'(cycles), 160'd1);
    check("inc20_pw", out_password, {{19{8'h20}}, 8'h21});
    check("inc20_len", {155'd0, out_length}, 160'd1);

    do_op("inc7d", {{19{8'h20}}, 8'h7D}, 5'd1, {{19{8'h20}}, 8'h7E}, 5'd1);
    do_op("grow1", {{18{8'h20}}, 8'h41, 8'h7E}, 5'd1, ALL_SP, 5'd2);
    do_op("len2", {{17{8'h20}}, 8'h5A, 16'h207E}, 5'd2, {{17{8'h20}}, 8'h5A, 16'h2120}, 5'd2);
    do_op("test", {{16{8'h20}}, 32'h54455354}, 5'd4, {{16{8'h20}}, 32'h54455355}, 5'd4);
    do_op("len6", {{14{8'h20}}, 48'h7E547E7E7E7E}, 5'd6, {{14{8'h20}}, 48'h7E5520202020}, 5'd6);
    do_op("low", {{19{8'h20}}, 8'h05}, 5'd1, {{19{8'h20}}, 8'h06}, 5'd1);
    do_op("clamp", ALL_SP, 5'd25, {{19{8'h20}}, 8'h21}, 5'd20);

    start_op({20{8'h7E}}, 5'd20);
    wait_done(cycles);
    check("ovf_lat", 160'(cycles), 160'd21);
    check("ovf_pw", out_password, ALL_SP);
    check("ovf_len", {155'd0, out_length}, 160'd21);

    // Trigger held high across several edges: one operation, completed never drops.
    @(negedge clk);
    in_password = {{19{8'h20}}, 8'h40};
    in_length   = 5'd1;
    trigger     = 1'b1;
    @(posedge clk);
    #1;
    done_all = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      done_all = done_all & completed;
    end
    trigger = 1'b0;
    check("hold_done", {159'd0, done_all}, 160'd1);
    check("hold_pw", out_password, {{19{8'h20}}, 8'h41});
    $display("op hold: pw %h completed %b", out_password, completed);

    // Reset in the middle of a long carry chain.
    start_op({20{8'h7E}}, 5'd20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    nrst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_pw", out_password, ALL_SP);
    check("mid_rst_len", {155'd0, out_length}, 160'd0);
    check("mid_rst_done", {159'd0, completed}, 160'd0);
    $display("op mid_rst: len %0d completed %b", out_length, completed);
    @(negedge clk);
    nrst = 1'b1;

    do_op("post_rst", {{18{8'h20}}, 16'h217E}, 5'd2, {{18{8'h20}}, 16'h2220}, 5'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
